// File: rtl/scan_loader_pkg.sv
// Shared types and constants for the scan chain loader.
package scan_loader_pkg;

  localparam int unsigned CHAIN_LEN_DEF = 256;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned BIT_CNT_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    DRAIN,
    FINISH
  } state_t;

endpackage

// File: rtl/scan_loader_serializer.sv
// Byte PISO toward scan_in plus SIPO capture of scan_out, with a wrapping bit counter.
module scan_loader_serializer
  import scan_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              shift,
  input  logic              scan_out,
  output logic              scan_in,
  output logic [BYTE_W-1:0] cap,
  output logic              last_bit
);

  logic [BYTE_W-1:0]    shreg;
  logic [BIT_CNT_W-1:0] bit_cnt;

  // LSB of the shift register drives the chain; capture fills from the top so bit 0 is the first sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      cap     <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= load_data;
      bit_cnt <= '0;
    end else if (shift) begin
      shreg   <= {1'b0, shreg[BYTE_W-1:1]};
      cap     <= {scan_out, cap[BYTE_W-1:1]};
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  assign scan_in  = shreg[0];
  assign last_bit = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));

endmodule

// File: rtl/scan_loader.sv
// Scan chain initiator: shifts an image byte stream in, returns displaced chain bytes.
// Optional XOR checksum of readback bytes enabled by SCAN_LOADER_CHECKSUM_EN.
module scan_loader
  import scan_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] checksum,
  output logic              scan_enable,
  output logic              scan_in,
  input  logic              scan_out
);

  localparam int unsigned NUM_BYTES  = CHAIN_LEN / BYTE_W;
  localparam int unsigned BYTE_CNT_W = $clog2(NUM_BYTES) + 1;

  state_t                state;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [BYTE_CNT_W-1:0] byte_cnt_nxt;
  logic                  in_hs;
  logic                  out_hs;
  logic                  last_bit;

  assign in_hs        = (state == FETCH) && in_valid && in_ready;
  assign out_hs       = (state == DRAIN) && out_valid && out_ready;
  assign byte_cnt_nxt = byte_cnt + BYTE_CNT_W'(1);

  scan_loader_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (in_hs),
    .load_data (in_data),
    .shift     (scan_enable),
    .scan_out  (scan_out),
    .scan_in   (scan_in),
    .cap       (out_data),
    .last_bit  (last_bit)
  );

  // Transfer sequencing; scan_enable is high exactly while in SHIFT so stalls never move the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      scan_enable <= 1'b0;
      byte_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            byte_cnt <= '0;
          end
        end
        FETCH: begin
          if (in_hs) begin
            in_ready    <= 1'b0;
            scan_enable <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            scan_enable <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            byte_cnt  <= byte_cnt_nxt;
            if (byte_cnt_nxt == BYTE_CNT_W'(NUM_BYTES)) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              in_ready <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_LOADER_CHECKSUM_EN
  // Running XOR of delivered readback bytes; holds its final value until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (out_hs) begin
      checksum <= checksum ^ out_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_scan_loader.sv
// Scoreboard bench for scan_loader on a 16-bit behavioural chain with random images and backpressure.
module tb_scan_loader;

  localparam int unsigned CL = 16;
  localparam int unsigned NB = CL / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic [7:0]    checksum;
  logic          scan_enable;
  logic          scan_in;
  logic          scan_out;

  scan_loader #(.CHAIN_LEN(CL)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .checksum(checksum), .scan_enable(scan_enable),
    .scan_in(scan_in), .scan_out(scan_out)
  );

  always #5 clk = ~clk;

  // Behavioural chain: new bits enter at the top, the tail (bit 0) feeds scan_out.
  logic [CL-1:0] chain;
  logic          load_req = 1'b0;
  logic [CL-1:0] load_val = '0;
  assign scan_out = chain[0];
  always @(posedge clk) begin
    if (load_req) chain <= load_val;
    else if (scan_enable) chain <= {scan_in, chain[CL-1:1]};
  end

  int total = 0;
  int bad   = 0;
  logic [7:0]    exp_q[$];
  logic [CL-1:0] exp_chain;
  logic [7:0]    exp_ck;
  int shifts    = 0;
  int done_seen = 0;
  int exp_done  = 0;
  int hold      = 0;
  bit rand_rdy  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Output consumer with optional random or forced backpressure.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1'b1;
    end
  end

  // Monitor: pops expected readback bytes, checks hold behaviour, burst lengths and end-of-transfer state.
  int         burst = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      burst      = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid) chk("no_shift_in_drain", scan_enable, 0);
      if (scan_enable) begin
        burst++;
        shifts++;
      end else if (burst != 0) begin
        chk("burst_len", burst, 8);
        burst = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte got=%0h want=none", out_data);
        end else chk("readback", out_data, exp_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        done_seen++;
        chk("chain", chain, exp_chain);
        chk("checksum", checksum, exp_ck);
        chk("shift_total", shifts, CL);
        chk("queue_empty", exp_q.size(), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [CL-1:0] v);
    load_val = v;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_start(input logic [CL-1:0] img);
    exp_chain = img;
    exp_ck    = 8'h00;
    for (int k = 0; k < NB; k++) begin
      exp_q.push_back(chain[8*k +: 8]);
`ifdef SCAN_LOADER_CHECKSUM_EN
      exp_ck = exp_ck ^ chain[8*k +: 8];
`endif
    end
    shifts = 0;
    exp_done++;
    pulse_start();
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    bit ok = 0;
    repeat (gap) tick();
    in_data  = d;
    in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    tick();
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL in_timeout got=no_ready want=ready");
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    tick();
    tick();
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_timeout got=no_done want=done");
    end
    chk("done_count", done_seen, exp_done);
    chk("busy_idle", busy, 0);
  endtask

  logic [CL-1:0] img;
  logic [CL-1:0] snap;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    preload(16'h1234);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_scan_enable", scan_enable, 0);
    chk("rst_scan_in", scan_in, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_checksum", checksum, 0);
    rst = 1'b0;
    tick();

    // Directed load with output stall in DRAIN and input stall in FETCH.
    do_start(16'h3CA5);
    chk("busy_after_start", busy, 1);
    send_byte(8'hA5, 0);
    hold = 16;
    send_byte(8'h3C, 25);
    wait_done();
    chk("directed_chain", chain, 16'h3CA5);
`ifdef SCAN_LOADER_CHECKSUM_EN
    chk("directed_ck", checksum, 8'h26);
`else
    chk("directed_ck", checksum, 8'h00);
`endif

    // start while busy must be ignored.
    img = CL'($urandom);
    do_start(img);
    send_byte(img[7:0], 0);
    pulse_start();
    send_byte(img[15:8], 3);
    pulse_start();
    wait_done();

    // Reset in the middle of SHIFT aborts immediately and freezes the chain.
    preload(CL'($urandom));
    img = CL'($urandom);
    do_start(img);
    send_byte(img[7:0], 0);
    tick();
    tick();
    chk("mid_shift_active", scan_enable, 1);
    rst = 1'b1;
    #1;
    chk("abort_scan_enable", scan_enable, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    snap = chain;
    repeat (3) tick();
    chk("abort_chain_frozen", chain, snap);
    exp_q.delete();
    exp_done--;
    rst = 1'b0;
    tick();

    // Random images, random gaps, random backpressure.
    rand_rdy = 1;
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1) preload(CL'($urandom));
      img = CL'($urandom);
      do_start(img);
      for (int k = 0; k < NB; k++) send_byte(img[8*k +: 8], $urandom_range(0, 10));
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
